// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Multi-channel runtime-programmable integer clock divider.
//               Each channel emits a registered divided-clock level and a
//               one-cycle enable pulse at the start of every output period.
//               Ratio reloads take effect only at period boundaries (or on a
//               global sync), so no runt or stretched pulse is produced.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic                    pclk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       clk_en,
    output logic [NUM_CH-1:0]       div_busy
);

    // A ratio of 0 behaves exactly like 1, so the default is normalised once
    // here and every stored active ratio is kept non-zero from then on.
    localparam logic [DIV_W-1:0] c_def_raw = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] c_def_n   = (c_def_raw == '0) ? DIV_W'(1) : c_def_raw;
    localparam logic [DIV_W-1:0] c_def_cnt = c_def_n - DIV_W'(1);
    localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        logic [DIV_W-1:0] r_n;        // active ratio, never zero
        logic [DIV_W-1:0] r_p;        // pending ratio as written (may be zero)
        logic             r_pend;     // pending ratio waiting for a boundary
        logic [DIV_W-1:0] r_cnt;      // position within the current period
        logic             r_clk_out;
        logic             r_clk_en;

        logic [DIV_W-1:0] w_p_eff;
        logic             w_wrap;
        logic             w_apply;
        logic [DIV_W-1:0] w_n_next;
        logic [DIV_W-1:0] w_cnt_inc;
        logic [DIV_W-1:0] w_high;

        // Decode the period boundary and the ratio that governs the next cycle.
        always_comb begin
            w_p_eff   = (r_p == '0) ? c_one : r_p;
            w_wrap    = (r_cnt == (r_n - c_one));
            // A pending ratio is promoted on sync, or on a wrap while running.
            // The load strobe of this same edge is deliberately not looked at,
            // so a load coincident with a boundary waits for the next one.
            w_apply   = r_pend & (sync | (en & w_wrap));
            w_n_next  = w_apply ? w_p_eff : r_n;
            w_cnt_inc = w_wrap ? '0 : (r_cnt + c_one);
            // High time is ceil(N/2) so odd ratios spend the extra cycle high.
            w_high    = w_n_next - (w_n_next >> 1);
        end

        // Ratio bookkeeping, counter advance and registered output decode.
        always_ff @(posedge pclk) begin
            if (!rst_n) begin
                r_n       <= c_def_n;
                r_p       <= c_def_n;
                r_pend    <= 1'b0;
                r_cnt     <= c_def_cnt;
                r_clk_out <= 1'b0;
                r_clk_en  <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_n <= w_p_eff;
                end

                // A fresh load always leaves a pending value behind, even
                // when an older pending value is being consumed this edge.
                if (div_load[i]) begin
                    r_p    <= div_val[i*DIV_W +: DIV_W];
                    r_pend <= 1'b1;
                end else if (w_apply) begin
                    r_pend <= 1'b0;
                end

                if (sync) begin
                    r_cnt     <= '0;
                    r_clk_out <= 1'b1;
                    r_clk_en  <= 1'b1;
                end else if (en) begin
                    r_cnt     <= w_cnt_inc;
                    r_clk_out <= (w_cnt_inc < w_high);
                    r_clk_en  <= (w_cnt_inc == '0);
                end else begin
                    // Frozen: level and position hold, only the pulse drops.
                    r_clk_en  <= 1'b0;
                end
            end
        end

        assign clk_out[i]  = r_clk_out;
        assign clk_en[i]   = r_clk_en;
        assign div_busy[i] = r_pend;

    end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Directed self-checking bench for clk_div_prog with a
//               behavioural reference model feeding an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    localparam int NUM_CH  = 2;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 2;

    logic                    pclk;
    logic                    rst_n;
    logic                    en;
    logic                    sync;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       clk_en;
    logic [NUM_CH-1:0]       div_busy;

    clk_div_prog #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) u_dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .clk_en   (clk_en),
        .div_busy (div_busy)
    );

    // Free-running pixel clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct {
        logic [NUM_CH-1:0] co;
        logic [NUM_CH-1:0] ce;
        logic [NUM_CH-1:0] bz;
        string             tag;
    } exp_t;

    exp_t q_exp[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: integer ratios, zero already mapped to one.
    int m_n   [NUM_CH];
    int m_p   [NUM_CH];
    int m_cnt [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_co  [NUM_CH];
    bit m_ce  [NUM_CH];

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            int ld_val;
            ld_val = int'(div_val[c*DIV_W +: DIV_W]);
            if (!rst_n) begin
                m_n[c]    = DEF_DIV;
                m_pend[c] = 1'b0;
                m_cnt[c]  = DEF_DIV - 1;
                m_co[c]   = 1'b0;
                m_ce[c]   = 1'b0;
            end else begin
                if (sync) begin
                    if (m_pend[c]) begin
                        m_n[c]    = (m_p[c] == 0) ? 1 : m_p[c];
                        m_pend[c] = 1'b0;
                    end
                    m_cnt[c] = 0;
                    m_co[c]  = 1'b1;
                    m_ce[c]  = 1'b1;
                end else if (en) begin
                    if (m_cnt[c] == m_n[c] - 1) begin
                        if (m_pend[c]) begin
                            m_n[c]    = (m_p[c] == 0) ? 1 : m_p[c];
                            m_pend[c] = 1'b0;
                        end
                        m_cnt[c] = 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                    m_co[c] = (m_cnt[c] < (m_n[c] + 1) / 2);
                    m_ce[c] = (m_cnt[c] == 0);
                end else begin
                    m_ce[c] = 1'b0;
                end
                if (div_load[c]) begin
                    m_p[c]    = ld_val;
                    m_pend[c] = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle: push the model's expectation, then pop and compare
    // against the DUT once its outputs have settled after the edge.
    task automatic cyc(input string tag);
        exp_t e;
        model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            e.co[c] = m_co[c];
            e.ce[c] = m_ce[c];
            e.bz[c] = m_pend[c];
        end
        e.tag = tag;
        q_exp.push_back(e);
        @(posedge pclk);
        #1;
        e = q_exp.pop_front();
        n_cmp++;
        assert (clk_out === e.co) else begin
            n_err++;
            $error("FAIL %s clk_out observed=%b expected=%b", e.tag, clk_out, e.co);
        end
        n_cmp++;
        assert (clk_en === e.ce) else begin
            n_err++;
            $error("FAIL %s clk_en observed=%b expected=%b", e.tag, clk_en, e.ce);
        end
        n_cmp++;
        assert (div_busy === e.bz) else begin
            n_err++;
            $error("FAIL %s div_busy observed=%b expected=%b", e.tag, div_busy, e.bz);
        end
    endtask

    task automatic load(input int ch, input int val);
        div_val[ch*DIV_W +: DIV_W] = DIV_W'(val);
        div_load[ch]               = 1'b1;
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) cyc(tag);
    endtask

    logic [3:0] c_def_pat;
    logic [4:0] c_n5_pat;

    initial begin
        c_def_pat = 4'b0101;   // clk_out 1,0,1,0 read LSB first
        c_n5_pat  = 5'b00111;  // clk_out 1,1,1,0,0 read LSB first
        for (int c = 0; c < NUM_CH; c++) begin
            m_p[c] = DEF_DIV;
        end
        rst_n    = 1'b0;
        en       = 1'b0;
        sync     = 1'b0;
        div_val  = '0;
        div_load = '0;

        // Reset values.
        run(2, "reset");
        n_cmp++;
        assert (clk_out === 2'b00 && clk_en === 2'b00 && div_busy === 2'b00) else begin
            n_err++;
            $error("FAIL reset_const out=%b en=%b busy=%b expected all zero", clk_out, clk_en, div_busy);
        end

        // Default ratio 2: clk_out and clk_en toggle 1,0,1,0.
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc("def_div2");
            n_cmp++;
            assert (clk_out[0] === c_def_pat[k] && clk_en[0] === c_def_pat[k]) else begin
                n_err++;
                $error("FAIL def_div2_const k=%0d out=%b en=%b expected=%b", k, clk_out[0], clk_en[0], c_def_pat[k]);
            end
        end

        // Move both channels to N=4.
        load(0, 4);
        load(1, 4);
        cyc("load4");
        div_load = '0;
        run(6, "run4");

        // Mid-period load of 5 on ch0; current period finishes first.
        for (int k = 0; k < 8 && m_cnt[0] != 1; k++) cyc("align4");
        load(0, 5);
        cyc("load5");
        div_load = '0;
        n_cmp++;
        assert (div_busy[0] === 1'b1) else begin
            n_err++;
            $error("FAIL busy_after_load observed=%b expected=1", div_busy[0]);
        end
        for (int k = 0; k < 8 && !(m_cnt[0] == 0 && m_n[0] == 5); k++) cyc("to_wrap5");
        for (int k = 0; k < 10; k++) begin
            cyc("run5");
            n_cmp++;
            assert (clk_out[0] === c_n5_pat[(k + 1) % 5]) else begin
                n_err++;
                $error("FAIL run5_const k=%0d observed=%b expected=%b", k, clk_out[0], c_n5_pat[(k + 1) % 5]);
            end
        end

        // ch1: load 3 then 6 before the wrap; 7 exactly on a wrap edge.
        for (int k = 0; k < 8 && m_cnt[1] != 0; k++) cyc("align_ch1");
        load(1, 3);
        cyc("load3");
        load(1, 6);
        cyc("load6");
        div_load = '0;
        for (int k = 0; k < 8 && m_cnt[1] != 3; k++) cyc("to_wrap_ch1");
        load(1, 7);
        cyc("load7_on_wrap");
        div_load = '0;
        n_cmp++;
        assert (div_busy[1] === 1'b1) else begin
            n_err++;
            $error("FAIL busy_load_on_wrap observed=%b expected=1", div_busy[1]);
        end
        run(16, "run6_then7");

        // ch0 N=3, ch1 N=4 out of phase, then sync with a pending ratio.
        load(0, 3);
        load(1, 4);
        cyc("load3_4");
        div_load = '0;
        run(12, "run3_4");
        load(0, 6);
        cyc("pend6");
        div_load = '0;
        cyc("pre_sync");
        sync = 1'b1;
        cyc("sync");
        sync = 1'b0;
        n_cmp++;
        assert (clk_out === 2'b11 && clk_en === 2'b11 && div_busy[0] === 1'b0) else begin
            n_err++;
            $error("FAIL sync_const out=%b en=%b busy=%b expected 11/11/0", clk_out, clk_en, div_busy);
        end
        run(8, "post_sync");

        // Freeze mid-high phase for 10 cycles and resume.
        for (int k = 0; k < 8 && m_cnt[0] != 1; k++) cyc("align_hold");
        en = 1'b0;
        run(10, "hold");
        n_cmp++;
        assert (clk_out[0] === 1'b1 && clk_en === 2'b00) else begin
            n_err++;
            $error("FAIL hold_const out=%b en=%b expected out0=1 en=00", clk_out, clk_en);
        end
        en = 1'b1;
        run(8, "resume");

        // Ratios 0 and 1 both behave as N=1.
        load(0, 0);
        load(1, 1);
        cyc("load0_1");
        div_load = '0;
        sync = 1'b1;
        cyc("sync_n1");
        sync = 1'b0;
        run(4, "run_n1");
        n_cmp++;
        assert (clk_out === 2'b11 && clk_en === 2'b11) else begin
            n_err++;
            $error("FAIL n1_const out=%b en=%b expected 11/11", clk_out, clk_en);
        end

        // Reset mid-period returns to the default ratio.
        load(0, 5);
        load(1, 3);
        sync = 1'b1;
        cyc("reload");
        div_load = '0;
        cyc("sync_reload");
        sync = 1'b0;
        run(2, "mid_period");
        rst_n = 1'b0;
        cyc("reset_mid");
        rst_n = 1'b1;
        run(6, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
